// File: rtl/fft16_r22_ctrl.sv
// fft16_r22_ctrl: sequences load, two radix-2^2 DIF stages over ping-pong banks, and digit-reversed unload
module fft16_r22_ctrl #(
  parameter int BF_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic       o_ld_wr_en,
  output logic [3:0] o_ld_addr,
  output logic       o_bf_enable,
  output logic       o_rd_bank,
  output logic [3:0] o_bf_rd_addr0,
  output logic [3:0] o_bf_rd_addr1,
  output logic [3:0] o_bf_rd_addr2,
  output logic [3:0] o_bf_rd_addr3,
  output logic [3:0] o_tw_idx1,
  output logic [3:0] o_tw_idx2,
  output logic [3:0] o_tw_idx3,
  output logic       o_wr_en,
  output logic       o_wr_bank,
  output logic [3:0] o_wr_addr0,
  output logic [3:0] o_wr_addr1,
  output logic [3:0] o_wr_addr2,
  output logic [3:0] o_wr_addr3,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [3:0] o_out_rd_addr,
  output logic       o_out_last
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STAGE0, S_DRAIN0, S_STAGE1, S_DRAIN1, S_UNLOAD
  } state_t;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_n, w_n_nxt;
  logic        r_done, w_done_nxt;
  logic [17:0] r_pipe [BF_LATENCY];
  logic [17:0] w_push;
  logic        w_drain_last;
  assign w_drain_last = r_n == 4'(BF_LATENCY - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < BF_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_n       <= w_n_nxt;
      r_done    <= w_done_nxt;
      r_pipe[0] <= w_push;
      for (int i = 1; i < BF_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  always_comb begin
    w_state_nxt   = r_state;
    w_n_nxt       = r_n;
    w_done_nxt    = 1'b0;
    o_in_ready    = 1'b0;
    o_ld_wr_en    = 1'b0;
    o_ld_addr     = '0;
    o_bf_enable   = 1'b0;
    o_rd_bank     = 1'b0;
    o_bf_rd_addr0 = '0;
    o_bf_rd_addr1 = '0;
    o_bf_rd_addr2 = '0;
    o_bf_rd_addr3 = '0;
    o_tw_idx1     = '0;
    o_tw_idx2     = '0;
    o_tw_idx3     = '0;
    o_out_valid   = 1'b0;
    o_out_rd_addr = '0;
    o_out_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = i_start ? S_LOAD : S_IDLE;
        w_n_nxt     = '0;
      end
      S_LOAD: begin
        o_in_ready  = 1'b1;
        o_ld_wr_en  = i_in_valid;
        o_ld_addr   = i_in_valid ? r_n : '0;
        w_n_nxt     = i_in_valid ? r_n + 4'd1 : r_n;
        w_state_nxt = (i_in_valid && r_n == 4'd15) ? S_STAGE0 : S_LOAD;
      end
      S_STAGE0: begin
        o_bf_enable   = 1'b1;
        o_bf_rd_addr0 = r_n;
        o_bf_rd_addr1 = r_n + 4'd4;
        o_bf_rd_addr2 = r_n + 4'd8;
        o_bf_rd_addr3 = r_n + 4'd12;
        o_tw_idx1     = r_n;
        o_tw_idx2     = r_n << 1;
        o_tw_idx3     = r_n + (r_n << 1);
        w_n_nxt       = r_n == 4'd3 ? '0 : r_n + 4'd1;
        w_state_nxt   = r_n == 4'd3 ? S_DRAIN0 : S_STAGE0;
      end
      S_DRAIN0: begin
        w_n_nxt     = w_drain_last ? '0 : r_n + 4'd1;
        w_state_nxt = w_drain_last ? S_STAGE1 : S_DRAIN0;
      end
      S_STAGE1: begin
        o_bf_enable   = 1'b1;
        o_rd_bank     = 1'b1;
        o_bf_rd_addr0 = {r_n[1:0], 2'd0};
        o_bf_rd_addr1 = {r_n[1:0], 2'd1};
        o_bf_rd_addr2 = {r_n[1:0], 2'd2};
        o_bf_rd_addr3 = {r_n[1:0], 2'd3};
        w_n_nxt       = r_n == 4'd3 ? '0 : r_n + 4'd1;
        w_state_nxt   = r_n == 4'd3 ? S_DRAIN1 : S_STAGE1;
      end
      S_DRAIN1: begin
        w_n_nxt     = w_drain_last ? '0 : r_n + 4'd1;
        w_state_nxt = w_drain_last ? S_UNLOAD : S_DRAIN1;
      end
      S_UNLOAD: begin
        o_out_valid   = 1'b1;
        o_out_rd_addr = {r_n[1:0], r_n[3:2]};
        o_out_last    = r_n == 4'd15;
        w_n_nxt       = i_out_ready ? r_n + 4'd1 : r_n;
        w_done_nxt    = i_out_ready && r_n == 4'd15;
        w_state_nxt   = w_done_nxt ? S_IDLE : S_UNLOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // In-place writes: outputs land at the addresses they were read from, in the other bank
  assign w_push = {o_bf_enable, r_state == S_STAGE0, o_bf_rd_addr0, o_bf_rd_addr1, o_bf_rd_addr2, o_bf_rd_addr3};
  assign {o_wr_en, o_wr_bank, o_wr_addr0, o_wr_addr1, o_wr_addr2, o_wr_addr3} = r_pipe[BF_LATENCY-1];
  assign o_busy = r_state != S_IDLE;
  assign o_done = r_done;
endmodule

// File: tb/tb_fft16_r22_ctrl.sv
// tb_fft16_r22_ctrl: directed checks of the FFT controller with BF_LATENCY=1 (dut_a) and 3 (dut_b)
module tb_fft16_r22_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic a_busy, a_done, a_in_ready, a_ld_wr_en, a_bf_en, a_rd_bank, a_wr_en, a_wr_bank, a_out_valid, a_out_last;
  logic [3:0] a_ld_addr, a_rd0, a_rd1, a_rd2, a_rd3, a_tw1, a_tw2, a_tw3, a_wr0, a_wr1, a_wr2, a_wr3, a_out_addr;
  logic b_busy, b_done, b_in_ready, b_ld_wr_en, b_bf_en, b_rd_bank, b_wr_en, b_wr_bank, b_out_valid, b_out_last;
  logic [3:0] b_ld_addr, b_rd0, b_rd1, b_rd2, b_rd3, b_tw1, b_tw2, b_tw3, b_wr0, b_wr1, b_wr2, b_wr3, b_out_addr;
  logic [47:0] bfv_a, bfv_b, exp;
  logic [63:0] allv_a, allv_b;
  logic [3:0] seq [16] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13, 4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15};
  int vec = 0, err = 0;
  always #5 clk = ~clk;
  assign bfv_a = {a_bf_en, a_rd_bank, a_rd0, a_rd1, a_rd2, a_rd3, a_tw1, a_tw2, a_tw3, a_wr_en, a_wr_bank, a_wr0, a_wr1, a_wr2, a_wr3};
  assign bfv_b = {b_bf_en, b_rd_bank, b_rd0, b_rd1, b_rd2, b_rd3, b_tw1, b_tw2, b_tw3, b_wr_en, b_wr_bank, b_wr0, b_wr1, b_wr2, b_wr3};
  assign allv_a = {a_busy, a_done, a_in_ready, a_ld_wr_en, a_ld_addr, a_out_valid, a_out_addr, a_out_last, bfv_a};
  assign allv_b = {b_busy, b_done, b_in_ready, b_ld_wr_en, b_ld_addr, b_out_valid, b_out_addr, b_out_last, bfv_b};
  fft16_r22_ctrl #(.BF_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start_a), .o_busy(a_busy), .o_done(a_done),
    .i_in_valid(in_valid), .o_in_ready(a_in_ready), .o_ld_wr_en(a_ld_wr_en), .o_ld_addr(a_ld_addr),
    .o_bf_enable(a_bf_en), .o_rd_bank(a_rd_bank),
    .o_bf_rd_addr0(a_rd0), .o_bf_rd_addr1(a_rd1), .o_bf_rd_addr2(a_rd2), .o_bf_rd_addr3(a_rd3),
    .o_tw_idx1(a_tw1), .o_tw_idx2(a_tw2), .o_tw_idx3(a_tw3),
    .o_wr_en(a_wr_en), .o_wr_bank(a_wr_bank),
    .o_wr_addr0(a_wr0), .o_wr_addr1(a_wr1), .o_wr_addr2(a_wr2), .o_wr_addr3(a_wr3),
    .o_out_valid(a_out_valid), .i_out_ready(out_ready), .o_out_rd_addr(a_out_addr), .o_out_last(a_out_last));
  fft16_r22_ctrl #(.BF_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start_b), .o_busy(b_busy), .o_done(b_done),
    .i_in_valid(in_valid), .o_in_ready(b_in_ready), .o_ld_wr_en(b_ld_wr_en), .o_ld_addr(b_ld_addr),
    .o_bf_enable(b_bf_en), .o_rd_bank(b_rd_bank),
    .o_bf_rd_addr0(b_rd0), .o_bf_rd_addr1(b_rd1), .o_bf_rd_addr2(b_rd2), .o_bf_rd_addr3(b_rd3),
    .o_tw_idx1(b_tw1), .o_tw_idx2(b_tw2), .o_tw_idx3(b_tw3),
    .o_wr_en(b_wr_en), .o_wr_bank(b_wr_bank),
    .o_wr_addr0(b_wr0), .o_wr_addr1(b_wr1), .o_wr_addr2(b_wr2), .o_wr_addr3(b_wr3),
    .o_out_valid(b_out_valid), .i_out_ready(out_ready), .o_out_rd_addr(b_out_addr), .o_out_last(b_out_last));

  // Feeds 16 back-to-back samples; returns at the negedge of the first STAGE0 cycle
  task automatic do_load();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1;
    vec++; if (allv_a !== 64'd0) begin err++; $display("FAIL reset_a got %h want 0", allv_a); end
    vec++; if (allv_b !== 64'd0) begin err++; $display("FAIL reset_b got %h want 0", allv_b); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    vec++; if (allv_a !== 64'd0) begin err++; $display("FAIL idle_a got %h want 0", allv_a); end
  endtask

  task automatic test_load();
    @(negedge clk); start_a = 1'b1; #1;
    vec++; if (a_busy !== 1'b0) begin err++; $display("FAIL idle_busy got %b want 0", a_busy); end
    @(negedge clk); start_a = 1'b0; #1;
    vec++; if ({a_busy, a_in_ready} !== 2'b11) begin err++; $display("FAIL load_entry got %b want 11", {a_busy, a_in_ready}); end
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        in_valid = 1'b0; start_a = 1'b1; #1;
        vec++; if ({a_in_ready, a_ld_wr_en, a_ld_addr} !== 6'b100000) begin err++; $display("FAIL load_gap got %b want 100000", {a_in_ready, a_ld_wr_en, a_ld_addr}); end
        @(negedge clk); start_a = 1'b0;
      end
      in_valid = 1'b1; #1;
      vec++; if ({a_in_ready, a_ld_wr_en, a_ld_addr} !== {2'b11, 4'(i)}) begin err++; $display("FAIL load_addr i=%0d got %b want %b", i, {a_in_ready, a_ld_wr_en, a_ld_addr}, {2'b11, 4'(i)}); end
      @(negedge clk);
    end
    in_valid = 1'b0; #1;
    vec++; if ({a_in_ready, a_bf_en} !== 2'b01) begin err++; $display("FAIL load_exit got %b want 01", {a_in_ready, a_bf_en}); end
  endtask

  task automatic test_stage0();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp = '0;
      if (k < 4) exp[47:18] = {2'b10, 4'(k), 4'(k+4), 4'(k+8), 4'(k+12), 4'(k), 4'(2*k), 4'(3*k)};
      if (k == 5) exp[47:18] = {2'b11, 4'd0, 4'd1, 4'd2, 4'd3, 12'd0};
      if (k >= 1 && k <= 4) exp[17:0] = {2'b11, 4'(k-1), 4'(k+3), 4'(k+7), 4'(k+11)};
      vec++; if (bfv_a !== exp) begin err++; $display("FAIL stage0 k=%0d got %h want %h", k, bfv_a, exp); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst_n = 1'b0; #1;
    vec++; if (allv_a !== 64'd0) begin err++; $display("FAIL reset_mid got %h want 0", allv_a); end
    @(negedge clk); #1;
    vec++; if ({a_busy, a_done} !== 2'b00) begin err++; $display("FAIL reset_nodone got %b want 00", {a_busy, a_done}); end
    rst_n = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; #1;
    vec++; if ({a_busy, a_in_ready} !== 2'b11) begin err++; $display("FAIL reset_restart got %b want 11", {a_busy, a_in_ready}); end
  endtask

  task automatic test_unload();
    int idx;
    do_load();
    for (int k = 2; k <= 10; k++) @(negedge clk);
    #1;
    vec++; if ({a_busy, a_out_valid} !== 2'b10) begin err++; $display("FAIL unload_early got %b want 10", {a_busy, a_out_valid}); end
    @(negedge clk); #1;
    vec++; if (a_out_valid !== 1'b1) begin err++; $display("FAIL unload_first got %b want 1", a_out_valid); end
    idx = 0;
    for (int j = 0; j < 40 && idx < 16; j++) begin
      if (j > 0) @(negedge clk);
      out_ready = (j % 2 == 0); #1;
      vec++; if ({a_out_valid, a_out_addr, a_out_last} !== {1'b1, seq[idx], 1'(idx == 15)}) begin err++; $display("FAIL unload idx=%0d got %b want %b", idx, {a_out_valid, a_out_addr, a_out_last}, {1'b1, seq[idx], 1'(idx == 15)}); end
      if (out_ready) idx++;
    end
    @(negedge clk); out_ready = 1'b0; #1;
    vec++; if ({a_done, a_busy, a_out_valid, a_out_last} !== 4'b1000) begin err++; $display("FAIL done_pulse got %b want 1000", {a_done, a_busy, a_out_valid, a_out_last}); end
  endtask

  task automatic test_back_to_back();
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; #1;
    vec++; if ({a_busy, a_in_ready, a_done} !== 3'b110) begin err++; $display("FAIL b2b_load got %b want 110", {a_busy, a_in_ready, a_done}); end
    do_load();
    vec++; if (bfv_a[47:18] !== {2'b10, 4'd0, 4'd4, 4'd8, 4'd12, 12'd0}) begin err++; $display("FAIL b2b_stage0 got %h", bfv_a[47:18]); end
    out_ready = 1'b1;
    for (int w = 0; w < 30 && !a_out_valid; w++) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      #1;
      vec++; if ({a_out_valid, a_out_addr, a_out_last} !== {1'b1, seq[i], 1'(i == 15)}) begin err++; $display("FAIL b2b_unload i=%0d got %b want %b", i, {a_out_valid, a_out_addr, a_out_last}, {1'b1, seq[i], 1'(i == 15)}); end
      @(negedge clk);
    end
    out_ready = 1'b0; #1;
    vec++; if ({a_done, a_busy} !== 2'b10) begin err++; $display("FAIL b2b_done got %b want 10", {a_done, a_busy}); end
  endtask

  task automatic test_stage1_l3();
    int g;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    do_load();
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      exp = '0;
      if (k <= 4) begin g = k - 1; exp[47:18] = {2'b10, 4'(g), 4'(g+4), 4'(g+8), 4'(g+12), 4'(g), 4'(2*g), 4'(3*g)}; end
      if (k >= 8 && k <= 11) begin g = k - 8; exp[47:18] = {2'b11, 4'(4*g), 4'(4*g+1), 4'(4*g+2), 4'(4*g+3), 12'd0}; end
      if (k >= 4 && k <= 7) begin g = k - 4; exp[17:0] = {2'b11, 4'(g), 4'(g+4), 4'(g+8), 4'(g+12)}; end
      if (k >= 11 && k <= 14) begin g = k - 11; exp[17:0] = {2'b10, 4'(4*g), 4'(4*g+1), 4'(4*g+2), 4'(4*g+3)}; end
      vec++; if (bfv_b !== exp) begin err++; $display("FAIL stage1_l3 k=%0d got %h want %h", k, bfv_b, exp); end
      vec++; if (b_bf_en && b_rd_bank && b_wr_en && b_wr_bank) begin err++; $display("FAIL bank1_overlap k=%0d got 1 want 0", k); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stage0();
    test_reset_mid();
    test_unload();
    test_back_to_back();
    test_stage1_l3();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
